// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: owns the single code_mem port, runs a load
// phase (loader writes from address 0, optional zero-fill of the tail), then
// hands the port to the IF stage. A reload request in RUN restarts the load.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   ld_valid_i/ld_data_i/   loader stream; ld_last_i marks the final word,
//   ld_last_i/ld_ready_o    a beat is accepted on ld_valid_i & ld_ready_o
//   reload_req_i            pulse in RUN: discard program, reload
//   if_addr_i, if_stall_o   IF word address; stall while IF does not own the port
//   mem_addr_o/mem_wdata_o/ code_mem port (combinational from state/inputs)
//   mem_we_o
//   boot_done_o             registered: a load phase has fully completed
//   load_cnt_o              registered: words accepted from the loader
module imem_load_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ZERO_FILL = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ld_valid_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              reload_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              boot_done_o,
    output logic [ADDR_W:0]   load_cnt_o
);

    // One extra bit so a full 2**ADDR_W word load is counted exactly.
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'((2 ** ADDR_W) - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] load_cnt_q, load_cnt_d;
    logic             boot_done_q, boot_done_d;

    // State register; reset takes priority over any in-flight load or fill.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_LOAD;
            wptr_q      <= '0;
            load_cnt_q  <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            load_cnt_q  <= load_cnt_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Next-state and port muxing.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        load_cnt_d  = load_cnt_q;
        boot_done_d = boot_done_q;
        ld_ready_o  = 1'b0;
        if_stall_o  = 1'b1;
        mem_addr_o  = wptr_q[ADDR_W-1:0];
        mem_wdata_o = 32'h0;
        mem_we_o    = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                ld_ready_o  = 1'b1;
                mem_wdata_o = ld_data_i;
                mem_we_o    = ld_valid_i;
                if (ld_valid_i) begin
                    wptr_d     = wptr_q + PTR_W'(1);
                    load_cnt_d = load_cnt_q + PTR_W'(1);
                    // The top address is an implicit last word.
                    if (ld_last_i || (wptr_q == LAST_ADDR)) begin
                        if ((ZERO_FILL != 0) && (wptr_q != LAST_ADDR)) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d     = ST_RUN;
                            boot_done_d = 1'b1;
                        end
                    end
                end
            end
            ST_FILL: begin
                mem_we_o = 1'b1;
                wptr_d   = wptr_q + PTR_W'(1);
                if (wptr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    boot_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if_stall_o = 1'b0;
                mem_addr_o = if_addr_i;
                if (reload_req_i) begin
                    state_d     = ST_LOAD;
                    wptr_d      = '0;
                    load_cnt_d  = '0;
                    boot_done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign boot_done_o = boot_done_q;
    assign load_cnt_o  = load_cnt_q;

endmodule
